// File: rtl/audio_output_stage.sv
// Audio output stage: first-order de-emphasis, soft-mute gain ramp and a
// first-order sigma-delta PDM modulator, all paced by the 32 kHz audio enable.
module audio_output_stage #(
   parameter int DEEMPH_SHIFT = 1,
   parameter int RAMP_LOG2    = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en_a,
   input  logic signed [15:0] demodulated,
   input  logic               mute,
   output logic signed [15:0] sample_out,
   output logic               muted,
   output logic               pdm
);

   localparam int GW = RAMP_LOG2 + 1;
   localparam int PW = 16 + RAMP_LOG2 + 1;
   localparam logic [GW-1:0] G_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

   localparam logic [1:0] ST_MUTED     = 2'd0;
   localparam logic [1:0] ST_RAMP_UP   = 2'd1;
   localparam logic [1:0] ST_UNMUTED   = 2'd2;
   localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

   logic signed [15:0] y_q, y_d;
   logic [GW-1:0]      g_q, g_d;
   logic [1:0]         state_q, state_d;
   logic               upd_q, upd_d;
   logic signed [15:0] sample_out_q, sample_out_d;
   logic [15:0]        acc_q, acc_d;
   logic               pdm_q, pdm_d;

   logic signed [16:0]   diff;
   logic signed [15:0]   diff_sh;
   logic [GW-1:0]        g_inc, g_dec;
   logic signed [PW-1:0] y_ext, g_ext, prod;
   logic [15:0]          u;
   logic [16:0]          sd_sum;

   // The shifted difference always fits in 16 bits, and y + diff_sh lies
   // between y and the input, so plain 16-bit addition never wraps.
   always_comb begin
      diff    = {demodulated[15], demodulated} - {y_q[15], y_q};
      diff_sh = 16'(diff >>> DEEMPH_SHIFT);
      y_d     = y_q;
      if (en_a) begin
         y_d = y_q + diff_sh;
      end
   end

   // Ramp reversals that land on 0 or G_MAX go straight to the end state so g
   // can never step outside 0..G_MAX.
   always_comb begin
      g_inc   = g_q + GW'(1);
      g_dec   = g_q - GW'(1);
      g_d     = g_q;
      state_d = state_q;
      if (en_a) begin
         case (state_q)
            ST_MUTED: begin
               if (!mute) begin
                  g_d     = GW'(1);
                  state_d = ST_RAMP_UP;
               end
            end
            ST_RAMP_UP: begin
               if (mute) begin
                  g_d     = g_dec;
                  state_d = (g_dec == '0) ? ST_MUTED : ST_RAMP_DOWN;
               end else begin
                  g_d     = g_inc;
                  state_d = (g_inc == G_MAX) ? ST_UNMUTED : ST_RAMP_UP;
               end
            end
            ST_UNMUTED: begin
               if (mute) begin
                  g_d     = G_MAX - GW'(1);
                  state_d = ST_RAMP_DOWN;
               end
            end
            ST_RAMP_DOWN: begin
               if (!mute) begin
                  g_d     = g_inc;
                  state_d = (g_inc == G_MAX) ? ST_UNMUTED : ST_RAMP_UP;
               end else begin
                  g_d     = g_dec;
                  state_d = (g_dec == '0) ? ST_MUTED : ST_RAMP_DOWN;
               end
            end
            default: begin
               g_d     = '0;
               state_d = ST_MUTED;
            end
         endcase
      end
   end

   always_comb begin
      upd_d        = en_a;
      y_ext        = {{(PW-16){y_q[15]}}, y_q};
      g_ext        = {{(PW-GW){1'b0}}, g_q};
      prod         = y_ext * g_ext;
      sample_out_d = sample_out_q;
      if (upd_q) begin
         sample_out_d = 16'(prod >>> RAMP_LOG2);
      end
   end

   // Offset-binary view of the sample; the carry out of the accumulator is the bit.
   always_comb begin
      u      = {~sample_out_q[15], sample_out_q[14:0]};
      sd_sum = {1'b0, acc_q} + {1'b0, u};
      acc_d  = sd_sum[15:0];
      pdm_d  = sd_sum[16];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         y_q          <= '0;
         g_q          <= '0;
         state_q      <= ST_MUTED;
         upd_q        <= 1'b0;
         sample_out_q <= '0;
         acc_q        <= '0;
         pdm_q        <= 1'b0;
      end else begin
         y_q          <= y_d;
         g_q          <= g_d;
         state_q      <= state_d;
         upd_q        <= upd_d;
         sample_out_q <= sample_out_d;
         acc_q        <= acc_d;
         pdm_q        <= pdm_d;
      end
   end

   assign sample_out = sample_out_q;
   assign muted      = (state_q == ST_MUTED);
   assign pdm        = pdm_q;

endmodule
